// File: rtl/waterfall_reader_pkg.sv
// -----------------------------------------------------------------------------
// waterfall_reader_pkg
//
// Purpose : Shared definitions for the waterfall frame reader. It holds the
//           reader state enumeration, the default geometry of the frequency
//           RAM, and the derived constants (COLS / ROWS / ROW_W). Helper
//           functions recompute the same constants for overridden parameters.
//
// Ports   : none (package)
// -----------------------------------------------------------------------------
package waterfall_reader_pkg;

    // Default geometry: 9-bit RAM address split into 4 row bits and 5 column
    // bits, which gives 16 rows of 32 bins each.
    localparam int WF_ADDR_W = 9;
    localparam int WF_DATA_W = 8;
    localparam int WF_COL_W  = 5;

    localparam int WF_ROW_W  = WF_ADDR_W - WF_COL_W;
    localparam int WF_COLS   = 1 << WF_COL_W;
    localparam int WF_ROWS   = 1 << WF_ROW_W;

    // Reader sequencing states.
    //   ST_IDLE  : waiting for start
    //   ST_READ  : issuing RAM reads for the frame
    //   ST_DRAIN : every read issued, waiting for the final pixel to leave
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } wf_state_t;

    // Row-index width for a given address/column split.
    function automatic int wf_row_w(input int addr_w, input int col_w);
        return addr_w - col_w;
    endfunction

    // Number of bins per row.
    function automatic int wf_cols(input int col_w);
        return 1 << col_w;
    endfunction

    // Number of rows held in the RAM.
    function automatic int wf_rows(input int addr_w, input int col_w);
        return 1 << (addr_w - col_w);
    endfunction

endpackage

// File: rtl/waterfall_reader_pix_skid.sv
// -----------------------------------------------------------------------------
// pix_skid
//
// Purpose : Two-entry output buffer between the RAM read port and the pixel
//           stream. Entry 0 (head) always drives the output, so the output
//           data stays stable while the consumer stalls. Entry 1 (tail)
//           catches the read that was already in flight when the stall began.
//           The caller keeps (occupancy + reads in flight) <= 2, which means
//           a push never arrives while the buffer is full without a pop.
//
// Ports   : clk      in   clock
//           i_rst    in   asynchronous active-high reset; empties the buffer
//           i_push   in   write i_data this cycle
//           i_data   in   WIDTH  entry to write
//           i_pop    in   consumer takes the head entry this cycle
//           o_valid  out  head entry is valid
//           o_data   out  WIDTH  head entry
//           o_count  out  2      number of valid entries (0..2)
// -----------------------------------------------------------------------------
module pix_skid #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    // A pop on an empty buffer is meaningless; ignore it.
    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    // Push only: fill the first free slot.
                    if (r_count == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Pop only: the tail moves up to the head.
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy is unchanged.
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/waterfall_reader.sv
// -----------------------------------------------------------------------------
// waterfall_reader
//
// Purpose : Streams one waterfall frame out of a frequency RAM for each start
//           pulse. Rows are sent newest first, starting at the head_row value
//           captured at start and walking backwards with wrap-around. Within
//           each row the bins go out in ascending column order. The RAM has a
//           one-cycle registered read. Read data lands in a two-entry skid
//           buffer, so the stream sustains one pixel per clock and can stall
//           without dropping or repeating data.
//
// Ports   : clk        in   sole clock (also the RAM read-port clock)
//           reset      in   asynchronous active-high reset
//           start      in   one-cycle frame request (acted on only when idle)
//           head_row   in   ROW_W   newest complete row in the RAM
//           r_addr     out  ADDR_W  RAM read address {row, col}
//           r_en       out  RAM read enable
//           r_data     in   DATA_W  RAM read data, valid one clk after r_en
//           pix_data   out  DATA_W  streamed bin magnitude
//           pix_valid  out  pix_data valid
//           pix_ready  in   downstream accepts (transfer = valid & ready)
//           pix_last   out  marks the final pixel of the frame
//           busy       out  frame in progress
// -----------------------------------------------------------------------------
module waterfall_reader
    import waterfall_reader_pkg::*;
#(
    parameter  int ADDR_W = WF_ADDR_W,
    parameter  int DATA_W = WF_DATA_W,
    parameter  int COL_W  = WF_COL_W,
    localparam int ROW_W  = wf_row_w(ADDR_W, COL_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  head_row,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_en,
    input  logic [DATA_W-1:0] r_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy
);

    localparam int COLS = wf_cols(COL_W);
    localparam int ROWS = wf_rows(ADDR_W, COL_W);

    // Sequencer state and frame position.
    wf_state_t        r_state;
    wf_state_t        w_state_next;
    logic [ROW_W-1:0] r_base_row;
    logic [ROW_W-1:0] r_row_cnt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] w_row;

    // Read pipeline: one read can be in flight. Its last-pixel tag travels
    // with it so that the tag and the data reach the buffer together.
    logic             r_inflight;
    logic             r_inflight_last;
    logic             w_issue;
    logic             w_final_read;

    // Output buffer interface.
    logic [1:0]       w_skid_count;
    logic [DATA_W:0]  w_skid_out;
    logic             w_pop;
    logic [2:0]       w_occ;

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    // ROW_W-bit subtraction gives the wrap from row 0 to row ROWS-1.
    assign w_row  = r_base_row - r_row_cnt;
    assign r_addr = {w_row, r_col};

    assign w_final_read = (r_row_cnt == ROW_W'(ROWS - 1)) &&
                          (r_col     == COL_W'(COLS - 1));

    // ------------------------------------------------------------------
    // Occupancy rule
    // ------------------------------------------------------------------
    // A pixel that leaves the buffer this cycle frees its slot for a read
    // issued this cycle, because that read's data lands one cycle later.
    // This is what allows one pixel per clock. It is the only path from
    // pix_ready to r_en. r_addr comes purely from registers.
    assign w_pop = pix_valid && pix_ready;
    assign w_occ = 3'(w_skid_count) + 3'(r_inflight) - 3'(w_pop);

    // ------------------------------------------------------------------
    // FSM: next state and read issue
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_issue = (w_occ < 3'd2);
                if (w_issue && w_final_read) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The frame ends when the tagged pixel is actually taken.
                if (w_pop && pix_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign r_en = w_issue;
    assign busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_base_row      <= '0;
            r_row_cnt       <= '0;
            r_col           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_final_read;

            if (r_state == ST_IDLE && start) begin
                // head_row is sampled only here, so later changes to it
                // during the frame have no effect.
                r_base_row <= head_row;
                r_row_cnt  <= '0;
                r_col      <= '0;
            end else if (w_issue) begin
                r_col <= r_col + COL_W'(1);
                if (r_col == COL_W'(COLS - 1)) begin
                    r_row_cnt <= r_row_cnt + ROW_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: {last, data}
    // ------------------------------------------------------------------
    pix_skid #(
        .WIDTH (DATA_W + 1)
    ) u_pix_skid (
        .clk     (clk),
        .i_rst   (reset),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, r_data}),
        .i_pop   (w_pop),
        .o_valid (pix_valid),
        .o_data  (w_skid_out),
        .o_count (w_skid_count)
    );

    assign pix_data = w_skid_out[DATA_W-1:0];
    // The head entry may still hold a stale tag after it has drained, so the
    // tag is qualified with valid.
    assign pix_last = pix_valid && w_skid_out[DATA_W];

endmodule

// File: tb/tb_waterfall_reader.sv
// -----------------------------------------------------------------------------
// tb_waterfall_reader
//
// Directed bench for waterfall_reader. It uses a registered-read RAM model
// preloaded with value = addr[7:0]. Each frame is driven and checked pixel by
// pixel against the expected newest-first row order.
// -----------------------------------------------------------------------------
module tb_waterfall_reader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int COL_W  = 5;
    localparam int ROW_W  = 4;
    localparam int NPIX   = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ROW_W-1:0]  head_row;
    logic [ADDR_W-1:0] r_addr;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              busy;

    logic [7:0] ram [NPIX];
    logic [7:0] rx  [NPIX];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    waterfall_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .COL_W  (COL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .head_row  (head_row),
        .r_addr    (r_addr),
        .r_en      (r_en),
        .r_data    (r_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .busy      (busy)
    );

    // Registered-read RAM: data is valid one clock after r_en.
    always @(posedge clk) begin
        if (r_en) r_data <= ram[r_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected value of the k-th pixel of a frame whose newest row is head.
    function automatic logic [7:0] exp_pix(input logic [3:0] head, input int k);
        logic [3:0] row;
        logic [4:0] col;
        logic [8:0] a;
        row = head - 4'(k / 32);
        col = 5'(k % 32);
        a   = {row, col};
        return a[7:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_r_en"},      32'(r_en),      32'd0);
        chk({tag, "_r_addr"},    32'(r_addr),    32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_last"},  32'(pix_last),  32'd0);
        chk({tag, "_pix_data"},  32'(pix_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Runs one frame. rnd selects random pix_ready. restart_at pulses start
    // together with that pixel's transfer. start_on_last pulses start in the
    // pix_last transfer cycle. reset_at asserts reset at that pixel with
    // pix_ready low, which aborts the frame.
    task automatic run_frame(input string name, input logic [3:0] head, input bit rnd,
                             input int restart_at, input bit start_on_last, input int reset_at);
        int   k;
        int   cyc;
        int   first_valid;
        int   last_cyc;
        bit   done;
        bit   aborted;
        bit   prev_stall;
        logic v;
        logic l;
        logic [7:0] d;
        logic [7:0] prev_d;
        logic       prev_l;
        k = 0; cyc = 0; first_valid = -1; last_cyc = -1;
        done = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
        prev_d = '0; prev_l = 1'b0;

        @(negedge clk);
        head_row  = head;
        start     = 1'b1;
        pix_ready = 1'b1;

        while (!done && !aborted && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start    = 1'b0;
            head_row = head + 4'd5;   // must not affect the running frame
            v = pix_valid;
            d = pix_data;
            l = pix_last;
            if (cyc == 1) chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
            if (prev_stall) begin
                chk({name, "_hold_valid"}, 32'(v), 32'd1);
                chk({name, "_hold_data"},  32'(d), 32'(prev_d));
                chk({name, "_hold_last"},  32'(l), 32'(prev_l));
            end
            if (v && first_valid < 0) first_valid = cyc;
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

            if (reset_at >= 0 && k == reset_at && v) begin
                pix_ready = 1'b0;
                reset     = 1'b1;
                @(negedge clk);
                chk_all_zero({name, "_midreset"});
                reset   = 1'b0;
                aborted = 1'b1;
            end else if (v && pix_ready) begin
                if (k < NPIX) begin
                    rx[k] = d;
                    chk({name, "_data"}, 32'(d), 32'(exp_pix(head, k)));
                    chk({name, "_last"}, 32'(l), 32'(k == NPIX - 1));
                end
                if (k == restart_at) start = 1'b1;
                if (l) begin
                    done     = 1'b1;
                    last_cyc = cyc;
                    if (start_on_last) start = 1'b1;
                end
                k++;
            end
            prev_stall = v && !pix_ready;
            prev_d     = d;
            prev_l     = l;
        end

        if (reset_at < 0) begin
            chk({name, "_done"},      32'(done), 32'd1);
            chk({name, "_transfers"}, 32'(k),    32'(NPIX));
            if (!rnd) begin
                chk({name, "_first_valid_cycle"}, 32'(first_valid), 32'd3);
                chk({name, "_valid_span"}, 32'(last_cyc - first_valid + 1), 32'(NPIX));
            end
            @(negedge clk);
            start = 1'b0;
            chk({name, "_busy_after_last"},  32'(busy),      32'd0);
            chk({name, "_valid_after_last"}, 32'(pix_valid), 32'd0);
            @(negedge clk);
            chk({name, "_still_idle"}, 32'(busy), 32'd0);
        end
        $display("frame %s head=%0d transfers=%0d first_valid_cycle=%0d aborted=%0d",
                 name, head, k, first_valid, aborted);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            ram[i] = 8'(i);
            rx[i]  = '0;
        end
        r_data    = '0;
        reset     = 1'b1;
        start     = 1'b0;
        head_row  = '0;
        pix_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_r_en", 32'(r_en), 32'd0);

        // Newest row 3, continuous ready.
        run_frame("A", 4'd3, 1'b0, -1, 1'b0, -1);
        chk("A_px0",   32'(rx[0]),   32'h60);
        chk("A_px31",  32'(rx[31]),  32'h7F);
        chk("A_px32",  32'(rx[32]),  32'h40);
        chk("A_px63",  32'(rx[63]),  32'h5F);
        chk("A_px511", 32'(rx[511]), 32'h9F);

        // Newest row 0: the second row must wrap to row 15.
        run_frame("B", 4'd0, 1'b0, -1, 1'b0, -1);
        chk("B_px0",  32'(rx[0]),  32'h00);
        chk("B_px32", 32'(rx[32]), 32'hE0);
        chk("B_px63", 32'(rx[63]), 32'hFF);

        // Random back-pressure.
        run_frame("C", 4'd3, 1'b1, -1, 1'b0, -1);
        chk("C_px32",  32'(rx[32]),  32'h40);
        chk("C_px511", 32'(rx[511]), 32'h9F);

        // start pulses during the frame and in the pix_last cycle are ignored.
        run_frame("D", 4'd3, 1'b0, 100, 1'b1, -1);

        // Reset in mid-frame with pix_ready low, then a clean frame follows.
        run_frame("E", 4'd7, 1'b1, -1, 1'b0, 200);
        @(negedge clk);
        chk("E_idle_after_reset", 32'(busy), 32'd0);
        run_frame("F", 4'd3, 1'b0, -1, 1'b0, -1);
        chk("F_px0",   32'(rx[0]),   32'h60);
        chk("F_px511", 32'(rx[511]), 32'h9F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
